instr_issue_unit: RTL and testbench

Issue-side controller for the 4-bit decode-and-execute datapath. It accepts instruction words over a valid/ready handshake and holds the 4×4-bit register file. It reads the source operands and drives `rs`/`rt`/`sel` into the combinational execute unit, then captures its `rd` result and writes it back. It is the initiator in front of the execute unit and turns that unit into a small multi-cycle processor core.

---
 rtl/instr_issue_unit.sv | 174 +++++++++++++++++
 tb/tb_instr_issue_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_unit.sv
// Issue controller for the 4-bit execute unit: handshake, 4x4 register file, EXEC/WB sequencing.
// Optional input FIFO enabled by defining ISSUE_FIFO_EN (depth FIFO_DEPTH).
module instr_issue_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [9:0] instr,
    output logic [3:0] ex_rs,
    output logic [3:0] ex_rt,
    output logic [2:0] ex_sel,
    input  logic [3:0] ex_rd,
    output logic       wb_valid,
    output logic [1:0] wb_addr,
    output logic [3:0] wb_data,
    output logic [7:0] retired,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] ir_q, ir_d;
    logic [3:0] res_q, res_d;
    logic [3:0] rf_q [4];
    logic [3:0] rf_d [4];
    logic [7:0] ret_q, ret_d;

    logic       issue_go;
    logic [9:0] issue_instr;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

`ifdef ISSUE_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [9:0]     fifo_q [FIFO_DEPTH];
    logic [9:0]     fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign full        = (cnt_q == FULL_CNT);
    assign empty       = (cnt_q == '0);
    assign push        = instr_valid && !full;
    assign pop         = (state_q == IDLE) && !empty;
    assign instr_ready = !full;
    assign issue_go    = pop;
    assign issue_instr = fifo_q[rd_q];

    // FIFO pointer/count update; full refuses a push even when popping
    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (push) begin
            fifo_d[wr_q] = instr;
            wr_d         = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            fifo_q <= fifo_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign instr_ready = (state_q == IDLE);
    assign issue_go    = instr_valid && instr_ready;
    assign issue_instr = instr;
`endif

    // Sequencer: next state, datapath drive and writeback
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        res_d    = res_q;
        rf_d     = rf_q;
        ret_d    = ret_q;
        ex_rs    = '0;
        ex_rt    = '0;
        ex_sel   = '0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (issue_go) begin
                    ir_d    = issue_instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ir_q[9]) begin
                    res_d = ir_q[3:0];
                end else begin
                    ex_rs  = rf_q[ir_q[3:2]];
                    ex_rt  = rf_q[ir_q[1:0]];
                    ex_sel = ir_q[8:6];
                    res_d  = ex_rd;
                end
                state_d = WB;
            end
            WB: begin
                wb_valid          = 1'b1;
                wb_addr           = ir_q[5:4];
                wb_data           = res_q;
                rf_d[ir_q[5:4]]   = res_q;
                ret_d             = ret_q + 8'd1;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            res_q   <= '0;
            ret_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            ret_q   <= ret_d;
            rf_q    <= rf_d;
        end
    end

    assign retired  = ret_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit with a stub execute unit.
// Define ISSUE_FIFO_EN for both files to exercise the FIFO build.
module tb_instr_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] instr;
    logic [3:0] ex_rs;
    logic [3:0] ex_rt;
    logic [2:0] ex_sel;
    logic [3:0] ex_rd;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic [7:0] retired;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    instr_issue_unit #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_sel     (ex_sel),
        .ex_rd      (ex_rd),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .retired    (retired),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // stub execute unit: op0 sub, op1 add, op2 or, op3 and,
    // op4 xor, op5 rotate-left, op6 xnor, op7 a|~b
    function automatic logic [3:0] exec_fn(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            3'd0:    return a - b;
            3'd1:    return a + b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return {a[2:0], a[3]};
            3'd6:    return ~(a ^ b);
            default: return a | ~b;
        endcase
    endfunction

    always_comb ex_rd = exec_fn(ex_sel, ex_rs, ex_rt);

    // reference model: architectural register file and retire count
    logic [3:0] mrf [4];
    logic [7:0] mret;

    task automatic model_apply(input logic [9:0] ins,
                               output logic [1:0] a,
                               output logic [3:0] d);
        a = ins[5:4];
        if (ins[9]) d = ins[3:0];
        else d = exec_fn(ins[8:6], mrf[ins[3:2]], mrf[ins[1:0]]);
        mrf[a] = d;
        mret   = mret + 8'd1;
    endtask

    function automatic logic [9:0] mk_li(input logic [1:0] rd,
                                         input logic [3:0] imm);
        return {1'b1, 3'd0, rd, imm};
    endfunction

    function automatic logic [9:0] mk_op(input logic [2:0] op,
                                         input logic [1:0] rd,
                                         input logic [1:0] rs,
                                         input logic [1:0] rt);
        return {1'b0, op, rd, rs, rt};
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_dbg(input logic [1:0] a, output logic [3:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // issue one instruction and check its writeback and rf update
    task automatic run_instr(input logic [9:0] ins,
                             input logic [1:0] ea,
                             input logic [3:0] ed,
                             input string nm);
        int n;
        logic [3:0] d;
        instr_valid = 1'b1;
        instr = ins;
        n = 0;
        while (!instr_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk({nm, "_ready_timeout"}, 0, 1);
        step();
        instr_valid = 1'b0;
        instr = 10'($urandom);
        n = 0;
        while (!wb_valid && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            chk({nm, "_wb_timeout"}, 0, 1);
        end else begin
            chk({nm, "_wb_addr"}, wb_addr, ea);
            chk({nm, "_wb_data"}, wb_data, ed);
            step();
            rd_dbg(ea, d);
            chk({nm, "_dbg"}, d, ed);
        end
    endtask

    typedef struct {
        logic [9:0] ins;
        logic [1:0] addr;
        logic [3:0] data;
        logic [7:0] ret;
    } vec_t;

    vec_t       vt [12];
    logic [9:0] seq [6];
    logic [5:0] expq [$];
    logic [5:0] e;
    int         acc [6];
    int         wbc [6];
    int         k;
    int         w;
    int         low_at;
    int         acc_at_low;
    int         wb_seen;
    logic       accepted;
    logic [1:0] ea;
    logic [3:0] ed;
    logic [3:0] d;
    logic [9:0] ri;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{mk_li(2'd1, 4'd5), 2'd1, 4'd5, 8'd1};
        vt[1]  = '{mk_li(2'd2, 4'd3), 2'd2, 4'd3, 8'd2};
        vt[2]  = '{mk_op(3'd0, 2'd0, 2'd1, 2'd2), 2'd0, 4'd2, 8'd3};
        vt[3]  = '{mk_li(2'd1, 4'd9), 2'd1, 4'd9, 8'd4};
        vt[4]  = '{mk_li(2'd2, 4'd9), 2'd2, 4'd9, 8'd5};
        vt[5]  = '{mk_op(3'd1, 2'd3, 2'd1, 2'd2), 2'd3, 4'd2, 8'd6};
        vt[6]  = '{mk_op(3'd5, 2'd0, 2'd1, 2'd1), 2'd0, 4'b0011, 8'd7};
        vt[7]  = '{mk_li(2'd1, 4'd3), 2'd1, 4'd3, 8'd8};
        vt[8]  = '{mk_li(2'd2, 4'd7), 2'd2, 4'd7, 8'd9};
        vt[9]  = '{mk_op(3'd6, 2'd0, 2'd1, 2'd2), 2'd0, 4'b1011, 8'd10};
        vt[10] = '{mk_op(3'd7, 2'd0, 2'd1, 2'd1), 2'd0, 4'b1111, 8'd11};
        vt[11] = '{mk_op(3'd3, 2'd0, 2'd1, 2'd2), 2'd0, 4'b0011, 8'd12};

        seq[0] = mk_li(2'd0, 4'd4);
        seq[1] = mk_li(2'd1, 4'd6);
        seq[2] = mk_op(3'd1, 2'd2, 2'd0, 2'd1);
        seq[3] = mk_op(3'd0, 2'd3, 2'd1, 2'd0);
        seq[4] = mk_li(2'd0, 4'd15);
        seq[5] = mk_op(3'd1, 2'd0, 2'd0, 2'd3);

        for (int i = 0; i < 4; i++) mrf[i] = '0;
        mret = '0;

        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // reset state
        chk("rst_ready", instr_ready, 1);
        chk("rst_ex", {ex_rs, ex_rt, ex_sel}, 0);
        chk("rst_wb", {wb_valid, wb_addr, wb_data}, 0);
        chk("rst_retired", retired, 0);
        for (int i = 0; i < 4; i++) begin
            rd_dbg(2'(i), d);
            chk("rst_rf", d, 0);
        end

        // directed vectors
        for (int i = 0; i < 12; i++) begin
            run_instr(vt[i].ins, vt[i].addr, vt[i].data, "vec");
            chk("vec_retired", retired, vt[i].ret);
            mrf[vt[i].addr] = vt[i].data;
            mret = mret + 8'd1;
        end
        rd_dbg(2'd0, d);
        chk("vec_r0_final", d, 4'b0011);

`ifndef ISSUE_FIFO_EN
        // valid held high: accepts and writebacks every 3 cycles
        k = 0;
        w = 0;
        instr_valid = 1'b1;
        instr = seq[0];
        for (int c = 0; c < 15; c++) begin
            accepted = 1'b0;
            if (wb_valid) begin
                if (w < 3) wbc[w] = c;
                w++;
                e = (expq.size() > 0) ? expq.pop_front() : 6'h3f;
                chk("seq_wb", {wb_addr, wb_data}, e);
            end
            if (instr_valid && instr_ready && k < 3) begin
                acc[k] = c;
                k++;
                accepted = 1'b1;
                model_apply(instr, ea, ed);
                expq.push_back({ea, ed});
            end
            step();
            if (accepted) begin
                if (k < 3) instr = seq[k];
                else instr_valid = 1'b0;
            end
        end
        chk("seq_accepts", k, 3);
        chk("seq_acc_gap1", acc[1] - acc[0], 3);
        chk("seq_acc_gap2", acc[2] - acc[1], 3);
        chk("seq_wb_count", w, 3);
        chk("seq_wb_gap1", wbc[1] - wbc[0], 3);
        chk("seq_wb_gap2", wbc[2] - wbc[1], 3);
        chk("seq_retired", retired, mret);
`else
        // back-to-back pushes fill the FIFO
        k = 0;
        w = 0;
        low_at = -1;
        acc_at_low = -1;
        instr_valid = 1'b1;
        instr = seq[0];
        for (int c = 0; c < 60; c++) begin
            accepted = 1'b0;
            if (wb_valid) begin
                w++;
                e = (expq.size() > 0) ? expq.pop_front() : 6'h3f;
                chk("fifo_wb", {wb_addr, wb_data}, e);
            end
            if (!instr_ready && low_at < 0) begin
                low_at = c;
                acc_at_low = k;
            end
            if (instr_valid && instr_ready && k < 6) begin
                k++;
                accepted = 1'b1;
                model_apply(instr, ea, ed);
                expq.push_back({ea, ed});
            end
            step();
            if (accepted) begin
                if (k < 6) instr = seq[k];
                else instr_valid = 1'b0;
            end
        end
        chk("fifo_ready_dropped", low_at >= 0, 1);
        chk("fifo_acc_at_full", acc_at_low, 6);
        chk("fifo_wb_count", w, 6);
        chk("fifo_retired", retired, mret);
`endif

        // reset during EXEC drops the in-flight instruction
        instr_valid = 1'b1;
        instr = mk_op(3'd1, 2'd3, 2'd1, 2'd2);
        k = 0;
        while (!instr_ready && k < 20) begin
            step();
            k++;
        end
        step();
        instr_valid = 1'b0;
        k = 0;
        while (ex_sel != 3'd1 && k < 10) begin
            step();
            k++;
        end
        chk("rst_mid_exec_reached", ex_sel, 1);
        rst_n = 1'b0;
        #2;
        chk("rst_async_retired", retired, 0);
        chk("rst_async_ex", {ex_rs, ex_rt, ex_sel}, 0);
        #1;
        rst_n = 1'b1;
        wb_seen = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (wb_valid) wb_seen++;
        end
        chk("rst_mid_no_wb", wb_seen, 0);
        chk("rst_mid_ready", instr_ready, 1);
        chk("rst_mid_retired", retired, 0);
        for (int i = 0; i < 4; i++) begin
            rd_dbg(2'(i), d);
            chk("rst_mid_rf", d, 0);
        end
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        mret = '0;

        // random instructions against the model, crossing retired wrap
        for (int i = 0; i < 262; i++) begin
            ri = 10'($urandom);
            model_apply(ri, ea, ed);
            run_instr(ri, ea, ed, "rnd");
            if (($urandom % 4) == 0) repeat ($urandom_range(1, 2)) step();
        end
        chk("rnd_retired_wrap", retired, mret);
        for (int i = 0; i < 4; i++) begin
            rd_dbg(2'(i), d);
            chk("rnd_rf", d, mrf[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
